// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access pipeline stage.
// Holds bus widths, memop encodings, FSM state encodings and small decode helpers.
// Imported by mem_stage and mem_byte_lane.
package mem_stage_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;
   localparam int MEM_OP_BUS   = 3;

   localparam logic [REG_BUS-1:0] ZERO_WORD  = '0;
   localparam logic               RST_ENABLE = 1'b0;

   typedef enum logic [MEM_OP_BUS-1:0] {
      EXE_MEM_NONE = 3'd0,
      EXE_MEM_LW   = 3'd1,
      EXE_MEM_LB   = 3'd2,
      EXE_MEM_LBU  = 3'd3,
      EXE_MEM_SW   = 3'd4,
      EXE_MEM_SB   = 3'd5
   } memop_e;

   typedef enum logic {
      MEM_ST_IDLE = 1'b0,
      MEM_ST_WAIT = 1'b1
   } mem_state_e;

   function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
      return (op == EXE_MEM_SW) || (op == EXE_MEM_SB);
   endfunction

   function automatic logic is_word(input logic [MEM_OP_BUS-1:0] op);
      return (op == EXE_MEM_LW) || (op == EXE_MEM_SW);
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for loads/stores: byte enables, replicated store data, load extract/extend.
// Ports: memop_i/off_i/sdata_i/rdata_i in; sel_o/wdata_o/ldata_o out. Purely combinational.
// Little-endian lanes: byte offset b selects bits [8b+7:8b].
module mem_byte_lane
   import mem_stage_pkg::*;
(
   input  logic [MEM_OP_BUS-1:0] memop_i,
   input  logic [1:0]            off_i,
   input  logic [REG_BUS-1:0]    sdata_i,
   input  logic [REG_BUS-1:0]    rdata_i,
   output logic [3:0]            sel_o,
   output logic [REG_BUS-1:0]    wdata_o,
   output logic [REG_BUS-1:0]    ldata_o
);

   logic [REG_BUS-1:0] rshift;
   logic [7:0]         rbyte;

   always_comb begin
      // Bring the addressed byte down to lane 0.
      rshift = rdata_i >> {off_i, 3'b000};
      rbyte  = rshift[7:0];

      sel_o   = 4'b0000;
      wdata_o = ZERO_WORD;
      ldata_o = ZERO_WORD;

      case (memop_i)
         EXE_MEM_LW: begin
            sel_o   = 4'b1111;
            ldata_o = rdata_i;
         end
         EXE_MEM_SW: begin
            sel_o   = 4'b1111;
            wdata_o = sdata_i;
         end
         EXE_MEM_LB: begin
            sel_o   = 4'b0001 << off_i;
            ldata_o = {{24{rbyte[7]}}, rbyte};
         end
         EXE_MEM_LBU: begin
            sel_o   = 4'b0001 << off_i;
            ldata_o = {24'h000000, rbyte};
         end
         EXE_MEM_SB: begin
            sel_o   = 4'b0001 << off_i;
            // Replicate so the byte sits on whichever lane sel enables.
            wdata_o = {4{sdata_i[7:0]}};
         end
         default: begin
            sel_o   = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers EX results, runs one outstanding req/ack bus transaction for
// loads/stores, stalls upstream while waiting, drives WB and mirrors the result to ID.
// Ports: clk/rst (sync active-low); EX inputs; bus req/ack; WB + ID forwarding outputs; excpt_o.
// Optional: define MEM_ALIGN_CHECK_EN to trap misaligned LW/SW instead of accessing the aligned word.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_i,
   input  logic [MEM_OP_BUS-1:0]   memop_i,
   input  logic [REG_ADDR_BUS-1:0] waddr_i,
   input  logic                    we_i,
   input  logic [REG_BUS-1:0]      wdata_i,
   input  logic [REG_BUS-1:0]      mem_addr_i,
   input  logic [REG_BUS-1:0]      mem_sdata_i,
   output logic                    stall_req_o,
   output logic                    bus_req_o,
   output logic                    bus_we_o,
   output logic [REG_BUS-1:0]      bus_addr_o,
   output logic [3:0]              bus_sel_o,
   output logic [REG_BUS-1:0]      bus_wdata_o,
   input  logic [REG_BUS-1:0]      bus_rdata_i,
   input  logic                    bus_ack_i,
   output logic                    valid_o,
   output logic [REG_ADDR_BUS-1:0] waddr_o,
   output logic                    we_o,
   output logic [REG_BUS-1:0]      wdata_o,
   output logic [REG_ADDR_BUS-1:0] waddr_id_o,
   output logic                    we_id_o,
   output logic [REG_BUS-1:0]      wdata_id_o,
   output logic                    excpt_o
);

   mem_state_e state_q, state_d;

   // Transaction context, captured on acceptance and held through WAIT.
   logic [REG_BUS-1:0]      ctx_addr_q,  ctx_addr_d;
   logic [REG_BUS-1:0]      ctx_sdata_q, ctx_sdata_d;
   logic [REG_ADDR_BUS-1:0] ctx_waddr_q, ctx_waddr_d;
   logic [MEM_OP_BUS-1:0]   ctx_memop_q, ctx_memop_d;
   logic                    ctx_we_q,    ctx_we_d;

   // Write-back registers.
   logic                    valid_q, valid_d;
   logic [REG_ADDR_BUS-1:0] waddr_q, waddr_d;
   logic                    we_q,    we_d;
   logic [REG_BUS-1:0]      wdata_q, wdata_d;
   logic                    excpt_q, excpt_d;

   logic                    misalign;
   logic                    in_wait;
   logic [3:0]              lane_sel;
   logic [REG_BUS-1:0]      lane_wdata;
   logic [REG_BUS-1:0]      lane_ldata;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = valid_i && is_word(memop_i) && (mem_addr_i[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   mem_byte_lane u_byte_lane (
      .memop_i (ctx_memop_q),
      .off_i   (ctx_addr_q[1:0]),
      .sdata_i (ctx_sdata_q),
      .rdata_i (bus_rdata_i),
      .sel_o   (lane_sel),
      .wdata_o (lane_wdata),
      .ldata_o (lane_ldata)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= MEM_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_ST_IDLE: begin
            if (valid_i && (memop_i != EXE_MEM_NONE) && !misalign) begin
               state_d = MEM_ST_WAIT;
            end
         end
         MEM_ST_WAIT: begin
            if (bus_ack_i) begin
               state_d = MEM_ST_IDLE;
            end
         end
         default: state_d = MEM_ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (state register only, no ack path) ----------------
   always_comb begin
      in_wait     = (state_q == MEM_ST_WAIT);
      stall_req_o = in_wait;
      bus_req_o   = in_wait;
      bus_we_o    = in_wait && is_store(ctx_memop_q);
      bus_addr_o  = in_wait ? {ctx_addr_q[31:2], 2'b00} : ZERO_WORD;
      bus_sel_o   = in_wait ? lane_sel : 4'b0000;
      bus_wdata_o = in_wait ? lane_wdata : ZERO_WORD;
   end

   // ---------------- Datapath next values ----------------
   always_comb begin
      ctx_addr_d  = ctx_addr_q;
      ctx_sdata_d = ctx_sdata_q;
      ctx_waddr_d = ctx_waddr_q;
      ctx_memop_d = ctx_memop_q;
      ctx_we_d    = ctx_we_q;
      valid_d     = 1'b0;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      excpt_d     = 1'b0;

      case (state_q)
         MEM_ST_IDLE: begin
            if (valid_i) begin
               if (memop_i == EXE_MEM_NONE) begin
                  valid_d = 1'b1;
                  waddr_d = waddr_i;
                  we_d    = we_i;
                  wdata_d = wdata_i;
               end else if (misalign) begin
                  // Retire as a non-writing instruction flagged with an exception.
                  valid_d = 1'b1;
                  waddr_d = waddr_i;
                  wdata_d = ZERO_WORD;
                  excpt_d = 1'b1;
               end else begin
                  ctx_addr_d  = mem_addr_i;
                  ctx_sdata_d = mem_sdata_i;
                  ctx_waddr_d = waddr_i;
                  ctx_memop_d = memop_i;
                  ctx_we_d    = we_i;
               end
            end
         end
         MEM_ST_WAIT: begin
            if (bus_ack_i) begin
               valid_d = 1'b1;
               waddr_d = ctx_waddr_q;
               if (is_store(ctx_memop_q)) begin
                  we_d    = 1'b0;
                  wdata_d = ZERO_WORD;
               end else begin
                  we_d    = ctx_we_q;
                  wdata_d = lane_ldata;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         ctx_addr_q  <= ZERO_WORD;
         ctx_sdata_q <= ZERO_WORD;
         ctx_waddr_q <= '0;
         ctx_memop_q <= EXE_MEM_NONE;
         ctx_we_q    <= 1'b0;
         valid_q     <= 1'b0;
         waddr_q     <= '0;
         we_q        <= 1'b0;
         wdata_q     <= ZERO_WORD;
         excpt_q     <= 1'b0;
      end else begin
         ctx_addr_q  <= ctx_addr_d;
         ctx_sdata_q <= ctx_sdata_d;
         ctx_waddr_q <= ctx_waddr_d;
         ctx_memop_q <= ctx_memop_d;
         ctx_we_q    <= ctx_we_d;
         valid_q     <= valid_d;
         waddr_q     <= waddr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         excpt_q     <= excpt_d;
      end
   end

   assign valid_o    = valid_q;
   assign waddr_o    = waddr_q;
   assign we_o       = we_q;
   assign wdata_o    = wdata_q;
   assign excpt_o    = excpt_q;

   // Forwarding only advertises a write when the WB slot actually holds a result.
   assign waddr_id_o = waddr_q;
   assign wdata_id_o = wdata_q;
   assign we_id_o    = we_q & valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ALU/load/store/idle mix
// checked against a transaction-level reference model built from arithmetic on the lane rules.
// Bus ack latency is randomized; garbage is driven on the EX inputs during WAIT.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [2:0]  memop_i;
   logic [4:0]  waddr_i;
   logic        we_i;
   logic [31:0] wdata_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_sdata_i;
   logic        stall_req_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        valid_o;
   logic [4:0]  waddr_o;
   logic        we_o;
   logic [31:0] wdata_o;
   logic [4:0]  waddr_id_o;
   logic        we_id_o;
   logic [31:0] wdata_id_o;
   logic        excpt_o;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .memop_i     (memop_i),
      .waddr_i     (waddr_i),
      .we_i        (we_i),
      .wdata_i     (wdata_i),
      .mem_addr_i  (mem_addr_i),
      .mem_sdata_i (mem_sdata_i),
      .stall_req_o (stall_req_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_sel_o   (bus_sel_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ack_i   (bus_ack_i),
      .valid_o     (valid_o),
      .waddr_o     (waddr_o),
      .we_o        (we_o),
      .wdata_o     (wdata_o),
      .waddr_id_o  (waddr_id_o),
      .we_id_o     (we_id_o),
      .wdata_id_o  (wdata_id_o),
      .excpt_o     (excpt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_sel(input logic [2:0] op, input logic [31:0] addr);
      int off;
      off = int'(addr % 4);
      if (op == EXE_MEM_LW || op == EXE_MEM_SW) return 4'd15;
      if (op == EXE_MEM_LB || op == EXE_MEM_LBU || op == EXE_MEM_SB) return 4'(2 ** off);
      return 4'd0;
   endfunction

   function automatic logic [31:0] ref_bus_wdata(input logic [2:0] op, input logic [31:0] sdata);
      if (op == EXE_MEM_SB) return (sdata % 256) * 32'h0101_0101;
      return sdata;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] rdata,
                                            input logic [31:0] addr);
      logic [31:0] b;
      b = (rdata / (32'd1 << (8 * (addr % 4)))) % 256;
      if (op == EXE_MEM_LB && b >= 128) return b - 32'd256;
      if (op == EXE_MEM_LW) return rdata;
      return b;
   endfunction

   function automatic bit ref_misalign(input logic [2:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
      return (op == EXE_MEM_LW || op == EXE_MEM_SW) && (addr % 4 != 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_quiet_bus(input string tag);
      check({tag, ".stall"}, 32'(stall_req_o), 32'd0);
      check({tag, ".req"},   32'(bus_req_o),   32'd0);
   endtask

   // ---------------- transaction tasks ----------------
   task automatic run_alu(input logic [4:0] wa, input logic we, input logic [31:0] wd,
                          input string tag);
      valid_i = 1'b1; memop_i = EXE_MEM_NONE; waddr_i = wa; we_i = we; wdata_i = wd;
      mem_addr_i = $urandom; mem_sdata_i = $urandom;
      bus_ack_i = 1'($urandom % 2);   // stray ack outside WAIT must be ignored
      bus_rdata_i = $urandom;
      step();
      bus_ack_i = 1'b0;
      check({tag, ".valid"}, 32'(valid_o), 32'd1);
      check({tag, ".we"},    32'(we_o), 32'(we));
      check({tag, ".waddr"}, 32'(waddr_o), 32'(wa));
      check({tag, ".wdata"}, wdata_o, wd);
      check({tag, ".we_id"}, 32'(we_id_o), 32'(we));
      check({tag, ".wdata_id"}, wdata_id_o, wd);
      check({tag, ".excpt"}, 32'(excpt_o), 32'd0);
      check_quiet_bus(tag);
   endtask

   task automatic run_idle(input string tag);
      valid_i = 1'b0; memop_i = 3'($urandom % 6);
      step();
      check({tag, ".valid"}, 32'(valid_o), 32'd0);
      check({tag, ".we"},    32'(we_o), 32'd0);
      check({tag, ".we_id"}, 32'(we_id_o), 32'd0);
   endtask

   task automatic run_mem(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wa, input logic we, input int delay,
                          input logic [31:0] rdata, input string tag);
      bit st;
      int nstall;
      logic [31:0] exp_data;
      st = (op == EXE_MEM_SW || op == EXE_MEM_SB);
      valid_i = 1'b1; memop_i = op; waddr_i = wa; we_i = we; wdata_i = $urandom;
      mem_addr_i = addr; mem_sdata_i = sdata; bus_ack_i = 1'b0;
      step();
      if (ref_misalign(op, addr)) begin
         check({tag, ".mis_excpt"}, 32'(excpt_o), 32'd1);
         check({tag, ".mis_valid"}, 32'(valid_o), 32'd1);
         check({tag, ".mis_we"},    32'(we_o), 32'd0);
         check_quiet_bus(tag);
         valid_i = 1'b0;
         step();
         check({tag, ".mis_excpt_end"}, 32'(excpt_o), 32'd0);
         check({tag, ".mis_req_end"},   32'(bus_req_o), 32'd0);
      end else begin
         check({tag, ".acc_valid"}, 32'(valid_o), 32'd0);
         nstall = 0;
         for (int c = 0; c <= delay; c++) begin
            // EX presents junk while stalled; it must be ignored.
            valid_i = 1'b1; memop_i = 3'($urandom % 6); mem_addr_i = $urandom;
            waddr_i = 5'($urandom); wdata_i = $urandom;
            if (stall_req_o) nstall++;
            check({tag, ".req"},  32'(bus_req_o), 32'd1);
            check({tag, ".addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
            check({tag, ".sel"},  32'(bus_sel_o), 32'(ref_sel(op, addr)));
            check({tag, ".bwe"},  32'(bus_we_o), 32'(st));
            if (st) check({tag, ".bwdata"}, bus_wdata_o, ref_bus_wdata(op, sdata));
            if (c == delay) begin
               bus_ack_i = 1'b1; bus_rdata_i = rdata;
            end else begin
               bus_ack_i = 1'b0; bus_rdata_i = $urandom;
            end
            step();
         end
         bus_ack_i = 1'b0;
         valid_i = 1'b0;
         check({tag, ".nstall"}, 32'(nstall), 32'(delay + 1));
         check({tag, ".valid"},  32'(valid_o), 32'd1);
         check({tag, ".waddr"},  32'(waddr_o), 32'(wa));
         check({tag, ".we"},     32'(we_o), st ? 32'd0 : 32'(we));
         check({tag, ".we_id"},  32'(we_id_o), st ? 32'd0 : 32'(we));
         check({tag, ".excpt"},  32'(excpt_o), 32'd0);
         check_quiet_bus(tag);
         if (!st) begin
            exp_data = ref_load(op, rdata, addr);
            check({tag, ".ldata"},    wdata_o, exp_data);
            check({tag, ".ldata_id"}, wdata_id_o, exp_data);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".stall"},    32'(stall_req_o), 32'd0);
      check({tag, ".req"},      32'(bus_req_o), 32'd0);
      check({tag, ".bwe"},      32'(bus_we_o), 32'd0);
      check({tag, ".baddr"},    bus_addr_o, 32'd0);
      check({tag, ".bsel"},     32'(bus_sel_o), 32'd0);
      check({tag, ".bwdata"},   bus_wdata_o, 32'd0);
      check({tag, ".valid"},    32'(valid_o), 32'd0);
      check({tag, ".waddr"},    32'(waddr_o), 32'd0);
      check({tag, ".we"},       32'(we_o), 32'd0);
      check({tag, ".wdata"},    wdata_o, 32'd0);
      check({tag, ".we_id"},    32'(we_id_o), 32'd0);
      check({tag, ".excpt"},    32'(excpt_o), 32'd0);
   endtask

   initial begin
      logic [2:0] op;
      rst = 1'b0; valid_i = 1'b0; memop_i = '0; waddr_i = '0; we_i = 1'b0; wdata_i = '0;
      mem_addr_i = '0; mem_sdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b1;

      // Directed cases.
      run_alu(5'd5, 1'b1, 32'h1234_5678, "alu");
      run_mem(EXE_MEM_LW, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF, "lw");
      check("lw.exact", wdata_o, 32'hDEAD_BEEF);
      run_mem(EXE_MEM_LB, 32'h103, 32'h0, 5'd8, 1'b1, 1, 32'h80FF_0000, "lb");
      check("lb.exact", wdata_o, 32'hFFFF_FF80);
      run_mem(EXE_MEM_LBU, 32'h103, 32'h0, 5'd9, 1'b1, 0, 32'h80FF_0000, "lbu");
      check("lbu.exact", wdata_o, 32'h0000_0080);
      run_mem(EXE_MEM_SB, 32'h201, 32'h0000_00AB, 5'd10, 1'b1, 2, 32'h0, "sb");
      run_mem(EXE_MEM_SW, 32'h302, 32'hCAFE_F00D, 5'd11, 1'b0, 0, 32'h0, "sw_mis");
      run_idle("idle");

      // Reset while a transaction is pending.
      valid_i = 1'b1; memop_i = EXE_MEM_LW; mem_addr_i = 32'h400; waddr_i = 5'd3; we_i = 1'b1;
      step();
      valid_i = 1'b0;
      check("rstwait.pre_req", 32'(bus_req_o), 32'd1);
      rst = 1'b0;
      step();
      check("rstwait.req", 32'(bus_req_o), 32'd0);
      step();
      check_all_zero("rstwait");
      rst = 1'b1;
      run_alu(5'd12, 1'b1, 32'h0BAD_F00D, "post_rst_alu");

      // Randomized mix.
      for (int i = 0; i < 200; i++) begin
         int kind;
         kind = int'($urandom % 4);
         if (kind == 0) begin
            run_alu(5'($urandom), 1'($urandom), $urandom, "rnd_alu");
         end else if (kind == 1) begin
            run_idle("rnd_idle");
         end else begin
            op = 3'(1 + $urandom % 5);
            run_mem(op, $urandom, $urandom, 5'($urandom), 1'($urandom),
                    int'($urandom % 4), $urandom, "rnd_mem");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. Registers the EX result (destination, write enable, ALU data) and, for load/store operations, runs a single-outstanding request/acknowledge transaction on the data bus. Stalls the pipeline while a transaction is pending. Delivers the final write-back triple to WB, and mirrors it to ID for forwarding.

## Interface
- No parameters; widths come from `defines.v` (`RegBus`=32, `RegAddrBus`=5, `MemOpBus`=3).
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset
- valid_i  in  1  EX presents an instruction this cycle
- memop_i  in  3  NONE, LW, LB, LBU, SW, SB
- waddr_i  in  5  destination register
- we_i  in  1  register write enable
- wdata_i  in  32  ALU result (used when memop_i=NONE)
- mem_addr_i  in  32  byte address for load/store
- mem_sdata_i  in  32  store data
- stall_req_o  out  1  hold EX/ID/IF inputs stable
- bus_req_o, bus_we_o  out  1 each  request strobe, write flag
- bus_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- bus_sel_o  out  4  byte-lane enables (little-endian)
- bus_wdata_o  out  32  write data
- bus_rdata_i  in  32  read data, valid with ack
- bus_ack_i  in  1  transaction complete
- valid_o, waddr_o, we_o, wdata_o  out  1/5/1/32  to WB
- waddr_id_o, we_id_o, wdata_id_o  out  5/1/32  forwarding to ID
- excpt_o  out  1  misalignment flag (see Configuration)

## Operation
- FSM: IDLE, WAIT. Reset → IDLE.
- IDLE, valid_i=1, memop_i=NONE: next edge loads WB regs with waddr_i/we_i/wdata_i, valid_o=1.
- IDLE, valid_i=1, memop≠NONE: latch addr/sdata/waddr/memop/we into context regs; go WAIT; valid_o=0 next cycle.
- IDLE, valid_i=0: valid_o=0, we_o=0 next cycle.
- WAIT: bus_req_o=1 with address, sel, wdata, and we driven from context. valid_i is ignored.
- WAIT, bus_ack_i=1: load WB regs (load: extracted data, we from context; store: we_o=0) and set valid_o=1. Return to IDLE.
- Byte lanes, where b=addr[1:0]:
  - LB/SB: sel=4'b0001<<b.
  - SB: wdata={4{sdata[7:0]}}.
  - LB: rdata[8b+7:8b], sign-extended.
  - LBU: same byte, zero-extended.
  - LW/SW: sel=4'b1111, word passes through.
- Forwarding outputs: waddr_id_o=waddr_o, wdata_id_o=wdata_o, we_id_o=we_o&valid_o.
- bus_ack_i outside WAIT is ignored.

## Timing
- Reset (rst=0 at edge): state=IDLE, all outputs 0, including bus_req_o, stall_req_o, valid_o, excpt_o.
- Reset during WAIT aborts the transaction; bus_req_o is low the cycle after the reset edge.
- stall_req_o = (state==WAIT), decoded from state register only, with no combinational path from bus_ack_i.
  - It is therefore high from the cycle after a mem op is accepted through the ack cycle.
- ALU op latency: 1 cycle (valid_i at edge N → valid_o after N).
- Mem op latency: acceptance edge N; bus_req_o high from N+1. Ack sampled at edge M → valid_o after M, stall_req_o low after M.
- Zero-wait bus (ack in first request cycle): 2 cycles total.
- Upstream holds the instruction following a mem op stable while stall_req_o=1. It is accepted on the first IDLE cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Condition: LW/SW with addr[1:0]≠0. No bus request is issued and no WAIT is entered.
  - Next cycle: excpt_o=1 for one cycle, valid_o=1, we_o=0.
- Undefined: addr[1:0] is ignored for word ops, excpt_o is tied 0, and misaligned words access the aligned word.

## Structure
- Constants in `defines.v`:
  - memop encodings `EXE_MEM_NONE/LW/LB/LBU/SW/SB` and `MemOpBus`
  - FSM encodings `MEM_ST_IDLE/WAIT`
  - existing `ZeroWord` and `RstEnable`-style values
- One combinational sub-module, `mem_byte_lane`: memop + addr[1:0] + sdata + rdata → sel, wdata, and load result.

## Test plan
- Reset: rst=0 for 2 cycles while in WAIT → bus_req_o=0, all outputs 0, state IDLE.
- ALU pass-through: valid_i, NONE, waddr=5, wdata=0x1234_5678 → next cycle valid_o=1, we_o=1, wdata_o=0x12345678, we_id_o=1.
- LW at 0x100, ack after 3 wait cycles, rdata=0xDEADBEEF:
  - stall_req_o high 4 cycles
  - bus_sel_o=4'hF
  - then wdata_o=0xDEADBEEF
- LB/LBU at 0x103, rdata=0x80FF_0000 → LB: 0xFFFFFF80; LBU: 0x00000080; bus_sel_o=4'b1000.
- SB at 0x201, sdata=0xAB → bus_addr_o=0x200, sel=4'b0010, wdata=0xABABABAB, bus_we_o=1, we_o=0 after ack.
- SW at 0x302:
  - with `MEM_ALIGN_CHECK_EN`: no bus_req_o, excpt_o pulses 1 cycle.
  - without: bus_addr_o=0x300, request issued.
